// File: rtl/lsu_pkg.sv
// lsu_pkg: shared state type, funct3 encodings and lane helpers for the load/store unit
package lsu_pkg;
    typedef enum logic [1:0] {IDLE, BUS, RESP} lsu_state_e;
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    function automatic logic [3:0] be_gen(input logic [2:0] f3, input logic [1:0] lo);
        return (f3[1:0] == 2'b00) ? (4'b0001 << lo) : (f3[1:0] == 2'b01) ? (4'b0011 << lo) : 4'b1111;
    endfunction
    function automatic logic [31:0] ld_extend(input logic [2:0] f3, input logic [1:0] lo, input logic [31:0] w);
        logic [31:0] s;
        s = w >> {lo, 3'b000};
        return (f3 == F3_B)  ? {{24{s[7]}}, s[7:0]} :
               (f3 == F3_BU) ? {24'b0, s[7:0]} :
               (f3 == F3_H)  ? {{16{s[15]}}, s[15:0]} :
               (f3 == F3_HU) ? {16'b0, s[15:0]} : w;
    endfunction
    // Stores have no unsigned forms; halves and words must be naturally aligned.
    function automatic logic req_ok(input logic we, input logic [2:0] f3, input logic [1:0] lo);
        logic legal, aligned;
        legal   = we ? (f3 inside {F3_B, F3_H, F3_W}) : (f3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
        aligned = (f3[1:0] == 2'b01) ? !lo[0] : (f3[1:0] == 2'b10) ? (lo == 2'b00) : 1'b1;
        return legal && aligned;
    endfunction
endpackage

// File: rtl/lsu_align.sv
// lsu_align: byte-enable generation, store lane replication and load extraction/extension
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  i_st_funct3,
    input  logic [1:0]  i_st_addr_lo,
    input  logic [31:0] i_wdata,
    output logic [3:0]  o_be,
    output logic [31:0] o_wdata,
    input  logic [2:0]  i_ld_funct3,
    input  logic [1:0]  i_ld_addr_lo,
    input  logic [31:0] i_rword,
    output logic [31:0] o_rdata
);
    always_comb begin
        o_be    = be_gen(i_st_funct3, i_st_addr_lo);
        o_wdata = (i_st_funct3[1:0] == 2'b00) ? {4{i_wdata[7:0]}} :
                  (i_st_funct3[1:0] == 2'b01) ? {2{i_wdata[15:0]}} : i_wdata;
        o_rdata = ld_extend(i_ld_funct3, i_ld_addr_lo, i_rword);
    end
endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: turns core loads/stores into one word-aligned req/ack bus access with timeout
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 16,
    parameter int TO_W    = $clog2(TIMEOUT) + 1
)(
    input  logic              clk,
    input  logic              arst_n,
    input  logic              lsu_valid,
    input  logic              lsu_we,
    input  logic [2:0]        lsu_funct3,
    input  logic [ADDR_W-1:0] lsu_addr,
    input  logic [31:0]       lsu_wdata,
    output logic              lsu_busy,
    output logic              lsu_done,
    output logic              lsu_err,
    output logic [31:0]       lsu_rdata,
    output logic              bus_req,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [3:0]        bus_be,
    output logic [31:0]       bus_wdata,
    input  logic              bus_ack,
    input  logic [31:0]       bus_rdata
);
    lsu_state_e        r_state;
    logic [ADDR_W-1:0] r_addr;
    logic [2:0]        r_funct3;
    logic [TO_W-1:0]   r_cnt;
    logic              r_req, r_we, r_done, r_err;
    logic [3:0]        r_be;
    logic [31:0]       r_wdata, r_rdata;
    logic [3:0]        w_be;
    logic [31:0]       w_wdata, w_rdata;
    logic              w_ok;

    lsu_align u_align (
        .i_st_funct3  (lsu_funct3),
        .i_st_addr_lo (lsu_addr[1:0]),
        .i_wdata      (lsu_wdata),
        .o_be         (w_be),
        .o_wdata      (w_wdata),
        .i_ld_funct3  (r_funct3),
        .i_ld_addr_lo (r_addr[1:0]),
        .i_rword      (bus_rdata),
        .o_rdata      (w_rdata)
    );

    assign w_ok = req_ok(lsu_we, lsu_funct3, lsu_addr[1:0]);

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_state  <= IDLE;
            r_addr   <= '0;
            r_funct3 <= '0;
            r_cnt    <= '0;
            r_req    <= 1'b0;
            r_we     <= 1'b0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
            r_be     <= '0;
            r_wdata  <= '0;
            r_rdata  <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: if (lsu_valid) begin
                    r_err   <= !w_ok;
                    r_rdata <= '0;
                    if (w_ok) begin
                        r_state  <= BUS;
                        r_req    <= 1'b1;
                        r_addr   <= lsu_addr;
                        r_we     <= lsu_we;
                        r_funct3 <= lsu_funct3;
                        r_be     <= w_be;
                        r_wdata  <= w_wdata;
                        r_cnt    <= '0;
                    end else begin
                        r_state <= RESP;
                        r_done  <= 1'b1;
                    end
                end
                // Ack wins over a timeout landing on the same edge.
                BUS: if (bus_ack) begin
                    r_state <= RESP;
                    r_req   <= 1'b0;
                    r_done  <= 1'b1;
                    r_rdata <= r_we ? '0 : w_rdata;
                end else if (r_cnt == TO_W'(TIMEOUT - 1)) begin
                    r_state <= RESP;
                    r_req   <= 1'b0;
                    r_done  <= 1'b1;
                    r_err   <= 1'b1;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign lsu_busy  = arst_n && (r_state == BUS || (r_state == IDLE && lsu_valid));
    assign lsu_done  = r_done;
    assign lsu_err   = r_err;
    assign lsu_rdata = r_rdata;
    assign bus_req   = r_req;
    assign bus_we    = r_we;
    assign bus_addr  = {r_addr[ADDR_W-1:2], 2'b00};
    assign bus_be    = r_be;
    assign bus_wdata = r_wdata;
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed and randomized accesses checked against an arithmetic reference model
module tb_load_store_unit;
    localparam int TIMEOUT = 16;
    logic        clk = 1'b0;
    logic        arst_n = 1'b0;
    logic        lsu_valid = 1'b0;
    logic        lsu_we = 1'b0;
    logic [2:0]  lsu_funct3 = 3'b000;
    logic [31:0] lsu_addr = 32'h0;
    logic [31:0] lsu_wdata = 32'h0;
    logic        lsu_busy, lsu_done, lsu_err;
    logic [31:0] lsu_rdata;
    logic        bus_req, bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic        bus_ack = 1'b0;
    logic [31:0] bus_rdata = 32'h0;
    int          n_checks = 0;
    int          n_errors = 0;

    always #5 clk = ~clk;

    load_store_unit #(.ADDR_W(32), .TIMEOUT(TIMEOUT), .TO_W(5)) dut (
        .clk        (clk),
        .arst_n     (arst_n),
        .lsu_valid  (lsu_valid),
        .lsu_we     (lsu_we),
        .lsu_funct3 (lsu_funct3),
        .lsu_addr   (lsu_addr),
        .lsu_wdata  (lsu_wdata),
        .lsu_busy   (lsu_busy),
        .lsu_done   (lsu_done),
        .lsu_err    (lsu_err),
        .lsu_rdata  (lsu_rdata),
        .bus_req    (bus_req),
        .bus_we     (bus_we),
        .bus_addr   (bus_addr),
        .bus_be     (bus_be),
        .bus_wdata  (bus_wdata),
        .bus_ack    (bus_ack),
        .bus_rdata  (bus_rdata)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic model_ok(input logic we, input logic [2:0] f3, input logic [31:0] a);
        int size = 1 << f3[1:0];
        logic legal = we ? (f3 <= 3'd2) : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
        return legal && (a % size == 0);
    endfunction

    function automatic logic [3:0] model_be(input logic [2:0] f3, input logic [31:0] a);
        int size = 1 << f3[1:0];
        int be = ((1 << size) - 1) << (a % 4);
        return be[3:0];
    endfunction

    function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] w);
        int size = 1 << f3[1:0];
        return (size == 1) ? {24'h0, w[7:0]} * 32'h0101_0101 :
               (size == 2) ? {16'h0, w[15:0]} * 32'h0001_0001 : w;
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] w);
        int nbits = 8 << f3[1:0];
        logic [31:0] mask = (nbits == 32) ? 32'hFFFF_FFFF : (32'd1 << nbits) - 32'd1;
        logic [31:0] v = (w >> (8 * (a % 4))) & mask;
        if (!f3[2] && nbits < 32 && v[nbits-1]) v = v | ~mask;
        return v;
    endfunction

    task automatic run_op(input logic we, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, input logic [31:0] rw, input int waits);
        logic        ok = model_ok(we, f3, a);
        logic        tmo = ok && waits >= TIMEOUT;
        logic [31:0] exp_rd = (!ok || tmo || we) ? 32'h0 : model_load(f3, a, rw);
        int          exp_done = !ok ? 1 : tmo ? TIMEOUT + 1 : waits + 2;
        int          exp_req = !ok ? 0 : tmo ? TIMEOUT : waits + 1;
        int          done_at = -1;
        int          reqs = 0;
        @(negedge clk);
        lsu_valid  = 1'b1;
        lsu_we     = we;
        lsu_funct3 = f3;
        lsu_addr   = a;
        lsu_wdata  = wd;
        bus_rdata  = rw;
        bus_ack    = 1'b0;
        #1 check("busy_accept", 32'(lsu_busy), 32'd1);
        for (int c = 1; c <= 40 && done_at < 0; c++) begin
            @(negedge clk);
            if (lsu_done) begin
                done_at = c;
                check("err", 32'(lsu_err), 32'(!ok || tmo));
                check("rdata", lsu_rdata, exp_rd);
                check("busy_done", 32'(lsu_busy), 32'd0);
            end else if (bus_req) begin
                reqs++;
                check("bus_addr", bus_addr, a & ~32'h3);
                check("bus_be", 32'(bus_be), 32'(model_be(f3, a)));
                check("bus_we", 32'(bus_we), 32'(we));
                if (we) check("bus_wdata", bus_wdata, model_wdata(f3, wd));
                check("busy_bus", 32'(lsu_busy), 32'd1);
                if (reqs == waits + 1) bus_ack = 1'b1;
            end
        end
        lsu_valid = 1'b0;
        bus_ack   = 1'b0;
        check("done_latency", 32'(done_at), 32'(exp_done));
        check("req_cycles", 32'(reqs), 32'(exp_req));
        @(negedge clk);
        check("done_pulse", 32'(lsu_done), 32'd0);
    endtask

    initial begin
        #1;
        check("rst_req", 32'(bus_req), 32'd0);
        check("rst_busy", 32'(lsu_busy), 32'd0);
        check("rst_done", 32'(lsu_done), 32'd0);
        check("rst_err", 32'(lsu_err), 32'd0);
        check("rst_rdata", lsu_rdata, 32'd0);
        check("rst_bus", {bus_addr[31:2], bus_we, 1'b0} | bus_wdata | 32'(bus_be), 32'd0);
        repeat (2) @(negedge clk);
        arst_n = 1'b1;

        run_op(1'b1, 3'b010, 32'h0000_0104, 32'hDEAD_BEEF, 32'h0, 2);
        run_op(1'b0, 3'b000, 32'h0000_0103, 32'h0, 32'h8000_0000, 0);
        run_op(1'b0, 3'b100, 32'h0000_0103, 32'h0, 32'h8000_0000, 1);
        run_op(1'b0, 3'b001, 32'h0000_0102, 32'h0, 32'h7FFF_0000, 0);
        run_op(1'b0, 3'b001, 32'h0000_0100, 32'h0, 32'h1234_8001, 0);
        run_op(1'b0, 3'b101, 32'h0000_0102, 32'h0, 32'hBEEF_0000, 3);
        run_op(1'b1, 3'b000, 32'h0000_0201, 32'h0000_00A5, 32'h0, 0);
        run_op(1'b1, 3'b001, 32'h0000_0202, 32'h0000_1234, 32'h0, 1);
        run_op(1'b0, 3'b010, 32'h0000_0102, 32'h0, 32'hFFFF_FFFF, 0);
        run_op(1'b0, 3'b011, 32'h0000_0100, 32'h0, 32'hFFFF_FFFF, 0);
        run_op(1'b1, 3'b100, 32'h0000_0100, 32'h55, 32'h0, 0);
        run_op(1'b0, 3'b110, 32'h0000_0100, 32'h0, 32'hFFFF_FFFF, 0);
        run_op(1'b0, 3'b010, 32'h0000_0400, 32'h0, 32'h1111_1111, 1000);
        run_op(1'b0, 3'b010, 32'h0000_0404, 32'h0, 32'h2222_2222, 0);
        run_op(1'b0, 3'b010, 32'h0000_0500, 32'h0, 32'hCAFE_F00D, TIMEOUT - 1);

        @(negedge clk);
        lsu_valid  = 1'b1;
        lsu_we     = 1'b0;
        lsu_funct3 = 3'b010;
        lsu_addr   = 32'h0000_0300;
        bus_ack    = 1'b0;
        repeat (3) @(negedge clk);
        check("req_before_rst", 32'(bus_req), 32'd1);
        arst_n = 1'b0;
        #1;
        check("rst_mid_req", 32'(bus_req), 32'd0);
        check("rst_mid_busy", 32'(lsu_busy), 32'd0);
        check("rst_mid_done", 32'(lsu_done), 32'd0);
        @(negedge clk);
        lsu_valid = 1'b0;
        arst_n    = 1'b1;
        run_op(1'b0, 3'b010, 32'h0000_0300, 32'h0, 32'h1234_5678, 1);

        for (int i = 0; i < 150; i++) begin
            run_op(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom, $urandom, $urandom,
                   ($urandom_range(0, 9) == 0) ? int'($urandom_range(13, 20)) : int'($urandom_range(0, 3)));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Memory-access stage downstream of the core datapath: consumes the ALU result (address), register-file read port 2 (store data), the memory-write enable and the load/store funct3.
- Converts each load/store into one word-aligned bus transaction with byte enables, over a req/ack handshake.
- Returns sign- or zero-extended load data to the result-select mux.
- Raises busy so the PC register and register-file write are held for the full access.

Parameters:
- ADDR_W, 32, byte-address width on core and bus sides
- TIMEOUT, 16, max cycles waiting for bus_ack before abort with error (>=2)
- TO_W, 5, timeout counter width, $clog2(TIMEOUT)+1

Ports:
- clk  in  1  clock, rising edge
- arst_n  in  1  asynchronous active-low reset
- lsu_valid  in  1  core requests access; held high until lsu_done
- lsu_we  in  1  1 = store, 0 = load
- lsu_funct3  in  3  size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
- lsu_addr  in  ADDR_W  byte address (ALU result)
- lsu_wdata  in  32  store data (register read port 2)
- lsu_busy  out  1  stall PC and register-file write
- lsu_done  out  1  one-cycle completion pulse
- lsu_err  out  1  valid with lsu_done: misaligned, illegal funct3 or timeout
- lsu_rdata  out  32  extended load data, valid with lsu_done
- bus_req  out  1  bus request
- bus_we  out  1  bus write
- bus_addr  out  ADDR_W  word address, [1:0] = 0
- bus_be  out  4  byte enables
- bus_wdata  out  32  lane-replicated store data
- bus_ack  in  1  bus completion, sampled while bus_req = 1
- bus_rdata  in  32  read word, valid with bus_ack

Behaviour:
- Reset (async assert, sync deassert): state IDLE; all outputs 0; timeout counter 0.
- Reset mid-transaction: bus_req drops immediately; the access is lost; no done pulse.
- FSM states: IDLE, BUS, RESP.
- IDLE:
  - lsu_valid = 1 with legal, aligned request: register addr/be/wdata/we/funct3, go BUS, assert lsu_busy.
  - Illegal funct3 (011, 11x; store with 1xx) or misaligned (H with addr[0] = 1; W with addr[1:0] != 0): go RESP with err = 1; no bus activity.
- BUS:
  - bus_req = 1; addr, be, we and wdata stable until ack.
  - bus_ack = 1: capture bus_rdata, go RESP.
  - Counter reaches TIMEOUT without ack: drop req, go RESP with err = 1.
- RESP:
  - lsu_done = 1 for one cycle; lsu_busy = 0; return to IDLE.
  - A new lsu_valid is accepted in the following cycle.
- Latency:
  - Request accepted at edge N; bus_req high from N.
  - Ack sampled at edge M gives lsu_done high in cycle M..M+1.
  - Minimum 2 cycles request-to-done with zero-wait ack; error path 1 cycle.
- lsu_busy = 1 in BUS, and combinationally in IDLE while lsu_valid = 1 (core stalls in the accept cycle).
- Byte enables: B = 0001 << addr[1:0]; H = 0011 << addr[1:0]; W = 1111.
- Store data: B replicated to all 4 lanes; H replicated to both halves; W passed through.
- Load extract: byte/half selected by addr[1:0]; B/H sign-extend from bit 7/15; BU/HU zero-extend.
- Error loads: lsu_rdata = 0.
- lsu_valid dropping mid-transaction is a core protocol violation; the transaction still completes.
- Inputs are ignored outside IDLE.
- Timeout counter saturates and clears on each new request.

Decomposition:
- Shared package lsu_pkg:
  - typedef lsu_state_e {IDLE, BUS, RESP}
  - funct3 constants F3_B/F3_H/F3_W/F3_BU/F3_HU
  - function be_gen(funct3, addr[1:0])
  - function ld_extend(funct3, addr[1:0], word)
- One natural sub-module: lsu_align, combinational byte-enable generation, store replication and load extension, unit-testable alone.
- FSM, registers and timeout stay in load_store_unit.

Test Plan:
- SW addr 0x0000_0104, wdata 0xDEADBEEF, ack after 2 waits -> bus_addr 0x104, be 1111, wdata 0xDEADBEEF; done 4 cycles after accept; err 0.
- LB addr 0x103, bus_rdata 0x80_00_00_00 -> lsu_rdata 0xFFFF_FF80. LBU same -> 0x0000_0080. LH addr 0x102, rdata 0x7FFF_0000 -> 0x0000_7FFF.
- SB addr 0x201, wdata 0x0000_00A5 -> be 0010, bus_wdata 0xA5A5A5A5. SH addr 0x202 -> be 1100.
- LW addr 0x102 -> no bus_req; done next cycle with err 1, rdata 0. funct3 011 -> same.
- bus_ack never asserted -> bus_req high exactly TIMEOUT (16) cycles; done with err 1; next request proceeds normally.
- arst_n low during BUS -> bus_req, lsu_busy, lsu_done all 0 immediately. After release, a fresh LW completes with err 0.
